watch_mode_ctrl: RTL and testbench
==================================

Name: watch_mode_ctrl

Overview:
Front-end controller for the digital watch. It synchronises and debounces the four raw push-buttons and sequences the top-level mode (clock / alarm / stopwatch). It tracks the set/edit phase and emits the one-cycle set/up/down command pulses and the 12/24 (dp) level that drive the clock datapath's mode FSM. It is the only block that writes mstate.

Parameters:
DEB_CYCLES, 20, consecutive equal synchronised samples required to accept a new button level
HOLD_CYCLES, 1250, up/down held-time before auto-repeat starts (0.5 s at 2500 ticks/s)
REPEAT_CYCLES, 250, auto-repeat period once started (0.1 s)
IDLE_CYCLES, 75000, edit-idle timeout (30 s at 2500 ticks/s)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high
btn_mode  input  1  raw mode button, asynchronous, active-high
btn_set  input  1  raw set button
btn_up  input  1  raw up button
btn_down  input  1  raw down button
mstate  output  2  top mode: 00 clock, 01 alarm, 10 stopwatch; 11 never driven
set_pulse  output  1  one-cycle set command
up_pulse  output  1  one-cycle increment command
down_pulse  output  1  one-cycle decrement command
dp  output  1  display format level, 0 = 24 h, 1 = 12 h
editing  output  1  high while edit phase != 0
edit_abort  output  1  one-cycle pulse on idle timeout

Behaviour:
- Reset is async, active-high. All outputs go to 0, phase = 0, all counters = 0, debounced levels = 0. Reset mid-edit discards the edit with no pulses.
- Per button: 2-flop synchroniser feeds a debounce counter.
  - Debounced level changes only after DEB_CYCLES consecutive samples that differ from the current level. Any sample equal to the current level resets the counter.
  - A rising edge of the debounced level is an event for exactly 1 cycle. Latency from raw edge to event is 2 + DEB_CYCLES cycles.
- Edit phase is 2 bits: 0 idle, 1 first field (hour), 2 second field (minute). editing = (phase != 0).
- Mode event:
  - Not editing: mstate advances 00 -> 01 -> 10 -> 00.
  - Editing: ignored.
- Set event:
  - mstate 10: set_pulse only, no phase change.
  - mstate 00/01: set_pulse plus phase advance 0 -> 1 -> 2 -> 0.
- Mode and set events in the same cycle while not editing: mode wins and set is dropped, so there is no set_pulse.
- Up/down events:
  - Up and down in the same cycle: both dropped.
  - mstate 00, phase 0: up toggles dp and emits no up_pulse; down is ignored.
  - All other cases: up -> up_pulse, down -> down_pulse.
  - All pulses appear 1 cycle after the event.
- Auto-repeat applies only while editing.
  - Repeat starts once exactly one of up/down has been held at debounced level 1 for HOLD_CYCLES after its event.
  - It then emits the matching pulse every REPEAT_CYCLES.
  - It stops on release, when the other button is also pressed, or when phase leaves edit.
- Idle timeout:
  - The counter runs only while editing.
  - It clears on any event or repeat pulse.
  - On reaching IDLE_CYCLES: edit_abort for 1 cycle, phase = 0, and the counter clears. mstate is unchanged.
- At most one of set_pulse/up_pulse/down_pulse is high in any cycle. Pulse priority when coincident internally: set > up > down. This also resolves a repeat pulse colliding with a set event.
- The counters use $clog2 widths and never wrap; they saturate or clear as specified above.

Decomposition:
- Shared package watch_pkg holds:
  - mstate encodings MS_CLOCK = 2'b00, MS_ALARM = 2'b01, MS_STOPW = 2'b10.
  - Phase encodings PH_IDLE, PH_F1, PH_F2.
  - Tick constant TICKS_PER_SEC = 2500.
- One sub-module, btn_debounce (synchroniser + debounce + rise-event, parameter DEB_CYCLES), instantiated four times.
- The mode/phase FSM, repeat timer and idle timer stay in watch_mode_ctrl.

Test Plan:
All scenarios use DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, IDLE_CYCLES=100.
1. Bouncy btn_mode (toggles every 2 cycles for 10 cycles, then stable high 10 cycles) -> exactly one mstate change, 00 -> 01. Three more clean presses -> 10, 00, 01.
2. mstate 00: set, set, set -> three set_pulses; phase 1, 2, 0; editing high only between the 1st and 3rd presses. A mode press while editing leaves mstate at 00.
3. mstate 00, phase 0: up pressed twice -> dp 0 -> 1 -> 0 with no up_pulse; down -> no output.
4. Editing phase 1: hold up for 50 cycles after its event -> one immediate up_pulse, then repeat pulses at +20, +25, +30, +35, +40, +45. Pressing down mid-hold stops repeats.
5. Editing phase 2 with no buttons for 100 cycles -> edit_abort pulses once, editing drops, mstate still 00. Simultaneous up+down events -> no pulse.
6. Assert reset during editing phase 1 with up held -> all outputs 0 immediately. After release, a held button produces no event until it is released and pressed again.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared encodings and helpers for the watch front-end controller.
package watch_pkg;

  localparam int unsigned TICKS_PER_SEC = 2500;

  typedef enum logic [1:0] {
    MS_CLOCK = 2'b00,
    MS_ALARM = 2'b01,
    MS_STOPW = 2'b10
  } mstate_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_F1   = 2'b01,
    PH_F2   = 2'b10
  } phase_e;

  function automatic mstate_e next_mstate(input mstate_e ms);
    case (ms)
      MS_CLOCK: next_mstate = MS_ALARM;
      MS_ALARM: next_mstate = MS_STOPW;
      default:  next_mstate = MS_CLOCK;
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_IDLE: next_phase = PH_F1;
      PH_F1:   next_phase = PH_F2;
      default: next_phase = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counting debouncer and one-cycle rise event for one button.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [1:0]    vld;
  logic          armed;
  logic [CW-1:0] cnt;

  // A button already held across reset must be seen low once before it can raise an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      vld   <= 2'b00;
      armed <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      vld  <= {vld[0], 1'b1};
      rise <= 1'b0;
      if (vld[1] && !s2)
        armed <= 1'b1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        rise  <= s2 && armed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch front-end: button conditioning, top-mode sequencing, edit phase, command pulses,
// auto-repeat and edit-idle timeout.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 20,
  parameter int unsigned HOLD_CYCLES   = 1250,
  parameter int unsigned REPEAT_CYCLES = 250,
  parameter int unsigned IDLE_CYCLES   = 75000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mstate,
  output logic       set_pulse,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       dp,
  output logic       editing,
  output logic       edit_abort
);

  localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned IW   = $clog2(IDLE_CYCLES + 1);

  logic [3:0] btn_raw;
  logic [3:0] lvl;
  logic [3:0] ev;
  logic       unused_lvl;

  assign btn_raw    = {btn_down, btn_up, btn_set, btn_mode};
  assign unused_lvl = ^lvl[1:0];

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[i]),
      .level (lvl[i]),
      .rise  (ev[i])
    );
  end

  mstate_e       ms_q;
  phase_e        ph_q;
  phase_e        ph_nxt;
  logic          rpt_on;
  logic          rpt_up;
  logic          rpt_fast;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_lim;
  logic [IW-1:0] idle_cnt;

  logic ed, clk_idle, mode_take, set_take, up_take, down_take;
  logic dp_toggle, up_cmd, down_cmd, rpt_stop, rpt_hit, any_ev, idle_hit;

  assign mstate = ms_q;

  // Event arbitration: mode beats set outside edit; coincident up+down cancel.
  always_comb begin
    ed        = (ph_q != PH_IDLE);
    clk_idle  = (ms_q == MS_CLOCK) && !ed;
    mode_take = ev[0] && !ed;
    set_take  = ev[1] && !mode_take;
    up_take   = ev[2] && !ev[3];
    down_take = ev[3] && !ev[2];
    dp_toggle = up_take && clk_idle;

    rpt_lim  = rpt_fast ? RW'(REPEAT_CYCLES) : RW'(HOLD_CYCLES);
    rpt_stop = !ed || (rpt_up ? (!lvl[2] || lvl[3]) : (!lvl[3] || lvl[2]));
    rpt_hit  = rpt_on && !rpt_stop && (rpt_cnt == rpt_lim);

    up_cmd   = (up_take && !clk_idle) || (rpt_hit && rpt_up);
    down_cmd = (down_take && !clk_idle) || (rpt_hit && !rpt_up);

    any_ev   = |ev || rpt_hit;
    idle_hit = ed && !any_ev && (idle_cnt == IW'(IDLE_CYCLES - 1));

    ph_nxt = ph_q;
    if (set_take && (ms_q != MS_STOPW))
      ph_nxt = next_phase(ph_q);
    else if (idle_hit)
      ph_nxt = PH_IDLE;
  end

  // Mode/phase FSM with registered command outputs and both timers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_q       <= MS_CLOCK;
      ph_q       <= PH_IDLE;
      editing    <= 1'b0;
      dp         <= 1'b0;
      set_pulse  <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      edit_abort <= 1'b0;
      rpt_on     <= 1'b0;
      rpt_up     <= 1'b0;
      rpt_fast   <= 1'b0;
      rpt_cnt    <= '0;
      idle_cnt   <= '0;
    end else begin
      set_pulse  <= set_take;
      up_pulse   <= up_cmd && !set_take;
      down_pulse <= down_cmd && !set_take && !up_cmd;
      edit_abort <= idle_hit;

      if (mode_take)
        ms_q <= next_mstate(ms_q);
      ph_q    <= ph_nxt;
      editing <= (ph_nxt != PH_IDLE);
      if (dp_toggle)
        dp <= !dp;

      // Repeat tracks the most recent lone up/down event taken during edit.
      if (ed && (up_take || down_take)) begin
        rpt_on   <= 1'b1;
        rpt_up   <= up_take;
        rpt_fast <= 1'b0;
        rpt_cnt  <= RW'(1);
      end else if (!rpt_on || rpt_stop) begin
        rpt_on   <= 1'b0;
        rpt_fast <= 1'b0;
        rpt_cnt  <= '0;
      end else if (rpt_hit) begin
        rpt_fast <= 1'b1;
        rpt_cnt  <= RW'(1);
      end else if (rpt_cnt != rpt_lim) begin
        rpt_cnt <= rpt_cnt + RW'(1);
      end

      if (!ed || any_ev || idle_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + IW'(1);
    end
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Directed bench for watch_mode_ctrl with small timing parameters.
module tb_watch_mode_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 5;
  localparam int unsigned IDLE = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [1:0] mstate;
  logic       set_pulse, up_pulse, down_pulse, dp, editing, edit_abort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_set = 0, n_up = 0, n_down = 0, n_abort = 0, n_mchg = 0, n_multi = 0;
  int last_set = 0, last_abort = 0;
  int up_q[$];
  logic [1:0] ms_prev = 2'b00;

  watch_mode_ctrl #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down),
    .mstate(mstate), .set_pulse(set_pulse), .up_pulse(up_pulse), .down_pulse(down_pulse),
    .dp(dp), .editing(editing), .edit_abort(edit_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (set_pulse)  begin n_set++;   last_set = cyc; end
    if (up_pulse)   begin n_up++;    up_q.push_back(cyc); end
    if (down_pulse) n_down++;
    if (edit_abort) begin n_abort++; last_abort = cyc; end
    if (int'(set_pulse) + int'(up_pulse) + int'(down_pulse) > 1) n_multi++;
    if (mstate != ms_prev) n_mchg++;
    ms_prev = mstate;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_set  = v;
      2: btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    drive(b, 1'b1);
    step(hold);
    drive(b, 1'b0);
    step(12);
  endtask

  int s0, u0, d0, m0, a0, t, p;

  initial begin
    step(3);
    check_eq("rst_outputs", {mstate, set_pulse, up_pulse, down_pulse, dp, editing, edit_abort}, 0);
    reset = 1'b0;
    step(5);

    // Bouncy mode press yields a single advance.
    m0 = n_mchg;
    for (int i = 0; i < 5; i++) begin
      drive(0, (i % 2) == 0);
      step(2);
    end
    drive(0, 1'b1);
    step(10);
    drive(0, 1'b0);
    step(12);
    check_eq("bounce_mchg", n_mchg - m0, 1);
    check_eq("bounce_ms", mstate, 2'b01);
    press(0, 8); check_eq("mode_10", mstate, 2'b10);
    s0 = n_set;
    press(1, 8);
    check_eq("stopw_set_pulse", n_set - s0, 1);
    check_eq("stopw_no_edit", editing, 0);
    press(0, 8); check_eq("mode_00", mstate, 2'b00);
    press(0, 8); check_eq("mode_01", mstate, 2'b01);
    press(0, 8); press(0, 8); check_eq("mode_back_00", mstate, 2'b00);

    // Set cycling through the edit phases; mode ignored while editing.
    s0 = n_set;
    press(1, 8); check_eq("set1_edit", editing, 1);
    press(0, 8); check_eq("mode_in_edit", mstate, 2'b00);
    press(1, 8); check_eq("set2_edit", editing, 1);
    press(1, 8); check_eq("set3_edit", editing, 0);
    check_eq("set_count", n_set - s0, 3);

    // Clock/idle: up toggles dp silently, down does nothing.
    u0 = n_up; d0 = n_down;
    press(2, 8); check_eq("dp_1", dp, 1);
    press(2, 8); check_eq("dp_0", dp, 0);
    press(3, 8); check_eq("dp_after_down", dp, 0);
    check_eq("no_up_pulse", n_up - u0, 0);
    check_eq("no_down_pulse", n_down - d0, 0);

    // Auto-repeat on a held up, stopped by down.
    press(1, 8);
    u0 = n_up; d0 = n_down;
    up_q.delete();
    drive(2, 1'b1);
    t = 0;
    while (up_q.size() == 0 && t < 30) begin step(1); t++; end
    check_eq("first_up_seen", up_q.size() > 0, 1);
    p = (up_q.size() > 0) ? up_q[0] : cyc;
    t = 0;
    while (cyc < p + 41 && t < 60) begin step(1); t++; end
    drive(3, 1'b1);
    step(15);
    drive(2, 1'b0);
    drive(3, 1'b0);
    step(15);
    check_eq("rpt_count", n_up - u0, 7);
    for (int k = 1; k <= 6; k++)
      check_eq($sformatf("rpt_off%0d", k),
               (up_q.size() > k) ? up_q[k] - up_q[0] : -1, 15 + 5 * k);
    check_eq("rpt_down_pulse", n_down - d0, 1);

    // Idle timeout in phase 2.
    a0 = n_abort;
    press(1, 8);
    check_eq("phase2_edit", editing, 1);
    t = 0;
    while (n_abort == a0 && t < 130) begin step(1); t++; end
    step(2);
    check_eq("abort_count", n_abort - a0, 1);
    check_eq("abort_latency", last_abort - last_set, 100);
    check_eq("abort_edit", editing, 0);
    check_eq("abort_ms", mstate, 2'b00);

    // Simultaneous up+down in edit produce nothing.
    press(1, 8);
    u0 = n_up; d0 = n_down;
    drive(2, 1'b1); drive(3, 1'b1);
    step(10);
    drive(2, 1'b0); drive(3, 1'b0);
    step(12);
    check_eq("both_no_up", n_up - u0, 0);
    check_eq("both_no_down", n_down - d0, 0);

    // Reset mid-edit (alarm mode, dp set, up held) then re-arm.
    press(1, 8); press(1, 8);
    press(2, 8); check_eq("pre_rst_dp", dp, 1);
    press(0, 8); check_eq("pre_rst_ms", mstate, 2'b01);
    press(1, 8);
    u0 = n_up;
    drive(2, 1'b1);
    step(10);
    check_eq("alarm_up_pulse", n_up - u0, 1);
    reset = 1'b1;
    #1;
    check_eq("rst_async", {mstate, set_pulse, up_pulse, down_pulse, dp, editing, edit_abort}, 0);
    step(3);
    reset = 1'b0;
    u0 = n_up;
    step(20);
    check_eq("held_no_event", dp, 0);
    check_eq("held_no_up", n_up - u0, 0);
    drive(2, 1'b0);
    step(12);
    press(2, 8);
    check_eq("rearm_dp", dp, 1);

    check_eq("pulse_onehot", n_multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
